xmtr: RTL and testbench

XMTR -- requirements
Module: xmtr

---
 rtl/xmtr_pkg.sv | 22 ++
 rtl/xmtr_hold.sv | 51 +++++
 rtl/xmtr.sv | 127 ++++++++++++
 tb/tb_xmtr.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/xmtr_pkg.sv
// Shared definitions for the xmtr transmitter and its matching receiver:
// header byte, FSM state encodings and bit-counter width.
package xmtr_pkg;

  // Header byte sent in front of every body byte (LSB first on the line).
  localparam logic [7:0] XMTR_MATCH = 8'hA5;

  // Bit counter width: 8 bits per header/body phase.
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } xmtr_state_e;

  // True on the final bit of a header or body phase.
  function automatic logic last_bit(input logic [CNT_W-1:0] cnt);
    return &cnt;
  endfunction

endpackage

// File: rtl/xmtr_hold.sv
// Holding register for the transmitter: one-byte buffer with full and sticky
// overrun flags. A byte is accepted when the buffer is empty or is being
// drained into the shifter on the same edge; otherwise the byte is dropped
// and overrun is raised until the next accepted byte.
module xmtr_hold
  import xmtr_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data_in,
  input  logic       take,
  output logic [7:0] hold_data,
  output logic       full,
  output logic       overrun
);

  logic       accept;
  logic [7:0] hold_q;
  logic       full_q;
  logic       overrun_q;

  assign accept    = load && (!full_q || take);
  assign hold_data = hold_q;
  assign full      = full_q;
  assign overrun   = overrun_q;

  // Flag register: accept sets full and clears overrun, rejected load sets
  // overrun, a drain without a new byte empties the buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else if (accept) begin
      full_q    <= 1'b1;
      overrun_q <= 1'b0;
    end else if (load) begin
      overrun_q <= 1'b1;
    end else if (take) begin
      full_q    <= 1'b0;
    end
  end

  // Data register is not reset; it only matters while full is set.
  always_ff @(posedge clock) begin
    if (!reset && accept) begin
      hold_q <= data_in;
    end
  end

endmodule

// File: rtl/xmtr.sv
// Serial byte transmitter. Each frame is 16 line cycles: the MATCH header
// LSB first, then the body byte MSB first. A one-byte holding register
// (xmtr_hold) lets the writer queue the next byte during a frame so frames
// run back to back.
// Build option: define XMTR_GAP_EN to insert one idle cycle between frames.
//
// Handshake: load is a one-cycle strobe qualifying data_in; the writer must
// wait while full=1, a load while full=1 (without a same-edge drain) is
// dropped and sets the sticky overrun flag.
module xmtr
  import xmtr_pkg::*;
#(
  parameter logic [7:0] MATCH = XMTR_MATCH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        load,
  output logic        serial_out,
  output logic        busy,
  output logic        full,
  output logic        overrun,
  output xmtr_state_e state_dbg
);

`ifdef XMTR_GAP_EN
  localparam logic GAP = 1'b1;
`else
  localparam logic GAP = 1'b0;
`endif

  xmtr_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [7:0]       shift_q, shift_d;
  logic             serial_q, serial_d;
  logic             take;
  logic [7:0]       hold_data;

  xmtr_hold u_hold (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .data_in   (data_in),
    .take      (take),
    .hold_data (hold_data),
    .full      (full),
    .overrun   (overrun)
  );

  assign cnt_nxt    = cnt_q + 1'b1;
  assign serial_out = serial_q;
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;

  // Next-state, counter, shifter and next line bit; serial_d is the value
  // the line shows during the next cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    serial_d = 1'b0;
    take     = 1'b0;
    case (state_q)
      IDLE: begin
        if (full) begin
          take     = 1'b1;
          shift_d  = hold_data;
          state_d  = HEAD;
          cnt_d    = '0;
          serial_d = MATCH[0];
        end
      end
      HEAD: begin
        if (last_bit(cnt_q)) begin
          state_d  = BODY;
          cnt_d    = '0;
          serial_d = shift_q[7];
          shift_d  = {shift_q[6:0], 1'b0};
        end else begin
          cnt_d    = cnt_nxt;
          serial_d = MATCH[cnt_nxt];
        end
      end
      BODY: begin
        if (!last_bit(cnt_q)) begin
          cnt_d    = cnt_nxt;
          serial_d = shift_q[7];
          shift_d  = {shift_q[6:0], 1'b0};
        end else if (full && !GAP) begin
          take     = 1'b1;
          shift_d  = hold_data;
          state_d  = HEAD;
          cnt_d    = '0;
          serial_d = MATCH[0];
        end else begin
          state_d  = IDLE;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state register; reset aborts any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      serial_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
    end
  end

  // Shift data register is not reset; it is reloaded at every frame start.
  always_ff @(posedge clock) begin
    if (!reset) begin
      shift_q <= shift_d;
    end
  end

endmodule

// File: tb/tb_xmtr.sv
// Directed testbench for xmtr. Outputs are sampled on the falling edge,
// inputs driven right after it. A line receiver model decodes every frame
// and scores the body against the expected queue.
module tb_xmtr;
  import xmtr_pkg::*;

  localparam logic [7:0] HDR = 8'hA5;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        load;
  logic        serial_out;
  logic        busy;
  logic        full;
  logic        overrun;
  xmtr_state_e state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  sched[16];
  logic [15:0] sched_en;

  int          rx_frames = 0;
  int          rx_n      = 0;
  logic [15:0] rx_sh;

  // clock/reset block
  always #5 clock = ~clock;

  xmtr dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .load       (load),
    .serial_out (serial_out),
    .busy       (busy),
    .full       (full),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver model + scoreboard: collects 16 busy cycles, checks header,
  // compares body with the next expected byte.
  always @(negedge clock) begin
    logic [7:0] h;
    if (reset) begin
      rx_n = 0;
    end else if (busy) begin
      rx_sh = {rx_sh[14:0], serial_out};
      rx_n++;
      if (rx_n == 16) begin
        for (int k = 0; k < 8; k++) h[k] = rx_sh[15-k];
        chk("rx_header", {24'd0, h}, {24'd0, HDR});
        chk("rx_pending", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) chk("rx_body", {24'd0, rx_sh[7:0]}, {24'd0, exp_q.pop_front()});
        rx_frames++;
        rx_n = 0;
      end
    end else if (rx_n != 0) begin
      chk("rx_truncated", rx_n, 0);
      rx_n = 0;
    end
  end

  // driver tasks
  task automatic start_idle(input logic [7:0] d);
    chk("pre_busy", {31'd0, busy}, 32'd0);
    data_in = d;
    load    = 1'b1;
    exp_q.push_back(d);
    @(negedge clock);
    load = 1'b0;
    chk("load_full", {31'd0, full}, 32'd1);
    chk("load_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
  endtask

  // Checks one frame slot by slot; optional loads per slot and reset at rst_at.
  task automatic frame_check(input logic [7:0] body, input int rst_at);
    logic [7:0] hv;
    logic       eb;
    hv = HDR;
    for (int i = 0; i < 16; i++) begin
      eb = (i < 8) ? hv[i] : body[15-i];
      chk($sformatf("busy_%02h_s%0d", body, i), {31'd0, busy}, 32'd1);
      chk($sformatf("serial_%02h_s%0d", body, i), {31'd0, serial_out}, {31'd0, eb});
      load    = sched_en[i];
      data_in = sched[i];
      if (i == rst_at) reset = 1'b1;
      @(negedge clock);
      load = 1'b0;
      if (i == rst_at) break;
    end
    sched_en = '0;
  endtask

  task automatic gap_check();
`ifdef XMTR_GAP_EN
    chk("gap_busy", {31'd0, busy}, 32'd0);
    chk("gap_serial", {31'd0, serial_out}, 32'd0);
    @(negedge clock);
`endif
  endtask

  task automatic idle_check();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_serial", {31'd0, serial_out}, 32'd0);
    @(negedge clock);
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    data_in  = 8'h00;
    sched_en = '0;
    for (int i = 0; i < 16; i++) sched[i] = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_serial", {31'd0, serial_out}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});

    // single frame 0x3C from idle
    start_idle(8'h3C);
    frame_check(8'h3C, -1);
    idle_check();
    idle_check();

    // 0x81 then 0x7E queued during the first frame: back-to-back
    start_idle(8'h81);
    sched[3] = 8'h7E; sched_en[3] = 1'b1; exp_q.push_back(8'h7E);
    frame_check(8'h81, -1);
    gap_check();
    frame_check(8'h7E, -1);
    idle_check();

    // overrun: 0x22 accepted, 0x33 and 0x44 dropped, 0x55 clears overrun
    start_idle(8'h11);
    sched[2] = 8'h22; sched_en[2] = 1'b1; exp_q.push_back(8'h22);
    sched[4] = 8'h33; sched_en[4] = 1'b1;
    sched[6] = 8'h44; sched_en[6] = 1'b1;
    frame_check(8'h11, -1);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    gap_check();
    chk("ovr_full_drained", {31'd0, full}, 32'd0);
    chk("ovr_held", {31'd0, overrun}, 32'd1);
    sched[3] = 8'h55; sched_en[3] = 1'b1; exp_q.push_back(8'h55);
    frame_check(8'h22, -1);
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);
    gap_check();
    frame_check(8'h55, -1);
    idle_check();

    // load on the idle->head transfer edge
    data_in = 8'h66; load = 1'b1; exp_q.push_back(8'h66);
    @(negedge clock);
    chk("coin_full0", {31'd0, full}, 32'd1);
    data_in = 8'h77; load = 1'b1; exp_q.push_back(8'h77);
    @(negedge clock);
    load = 1'b0;
    chk("coin_full", {31'd0, full}, 32'd1);
    chk("coin_overrun", {31'd0, overrun}, 32'd0);
    frame_check(8'h66, -1);
    gap_check();
    frame_check(8'h77, -1);
    idle_check();

    // reset at body bit 3 with a queued byte and overrun pending
    start_idle(8'hC3);
    sched[2] = 8'hD2; sched_en[2] = 1'b1;
    sched[4] = 8'hE1; sched_en[4] = 1'b1;
    frame_check(8'hC3, 11);
    chk("abort_serial", {31'd0, serial_out}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_full", {31'd0, full}, 32'd0);
    chk("abort_overrun", {31'd0, overrun}, 32'd0);
    exp_q.delete();
    data_in = 8'h99; load = 1'b1;
    @(negedge clock);
    reset = 1'b0; load = 1'b0;
    @(negedge clock);
    chk("rst_load_ignored", {31'd0, full}, 32'd0);
    chk("rst_load_busy", {31'd0, busy}, 32'd0);
    start_idle(8'hA5);
    frame_check(8'hA5, -1);
    idle_check();

    // loopback stream 0x00, 0xFF, 0xA5
    start_idle(8'h00);
    sched[5] = 8'hFF; sched_en[5] = 1'b1; exp_q.push_back(8'hFF);
    frame_check(8'h00, -1);
    gap_check();
    sched[5] = 8'hA5; sched_en[5] = 1'b1; exp_q.push_back(8'hA5);
    frame_check(8'hFF, -1);
    gap_check();
    frame_check(8'hA5, -1);
    idle_check();

    repeat (4) @(negedge clock);
    chk("rx_frames", rx_frames, 12);
    chk("exp_q_empty", exp_q.size(), 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
